// File: rtl/dp_pkg.sv
// Shared opcode encoding and decode helpers for the two-stage data path.
package dp_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_LOAD = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND  = 3'd3;
  localparam logic [OP_W-1:0] OP_OR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_MOVO = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP  = 3'd7;

  // LOAD and every ALU op retire into the register file.
  function automatic logic is_write(input logic [OP_W-1:0] op);
    return (op <= OP_XOR);
  endfunction
endpackage

// File: rtl/data_path_pipe_alu_ops.sv
// Combinational ALU: result plus carry value and which flags the op updates.
module alu_ops
  import dp_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic [OP_W-1:0]      op,
  output logic [BIT_WIDTH-1:0] res,
  output logic                 carry,
  output logic                 carry_upd,
  output logic                 zero_upd
);
  always_comb begin
    res       = '0;
    carry     = 1'b0;
    carry_upd = 1'b0;
    zero_upd  = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, res} = {1'b0, a} + {1'b0, b};
        carry_upd    = 1'b1;
        zero_upd     = 1'b1;
      end
      OP_SUB: begin
        // carry means "no borrow"
        res       = a - b;
        carry     = (a >= b);
        carry_upd = 1'b1;
        zero_upd  = 1'b1;
      end
      OP_AND: begin res = a & b; zero_upd = 1'b1; end
      OP_OR:  begin res = a | b; zero_upd = 1'b1; end
      OP_XOR: begin res = a ^ b; zero_upd = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_path_pipe.sv
// Register file + issue/execute pipeline with stage-2 -> stage-1 operand forwarding.
module data_path_pipe
  import dp_pkg::*;
#(
  parameter  int BIT_WIDTH = 8,
  parameter  int NUM_REGS  = 4,
  localparam int ADDR_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  input  logic [OP_W-1:0]      op,
  input  logic [ADDR_W-1:0]    rd,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  input  logic [BIT_WIDTH-1:0] in,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 cout,
  output logic                 zero
);
  logic [NUM_REGS-1:0][BIT_WIDTH-1:0] rf_q, rf_d;

  logic                 iss_vld_q, iss_vld_d;
  logic [OP_W-1:0]      iss_op_q,  iss_op_d;
  logic [ADDR_W-1:0]    iss_rd_q,  iss_rd_d;
  logic [BIT_WIDTH-1:0] iss_in_q,  iss_in_d;
  logic [BIT_WIDTH-1:0] iss_a_q,   iss_a_d;
  logic [BIT_WIDTH-1:0] iss_b_q,   iss_b_d;

  logic [BIT_WIDTH-1:0] out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic                 cout_q, cout_d;
  logic                 zero_q, zero_d;

  logic [BIT_WIDTH-1:0] alu_res;
  logic                 alu_carry, alu_carry_upd, alu_zero_upd;
  logic                 wb_en;
  logic [BIT_WIDTH-1:0] wb_data;
  logic [BIT_WIDTH-1:0] a_rf, b_rf;

  alu_ops #(.BIT_WIDTH(BIT_WIDTH)) u_alu (
    .a         (iss_a_q),
    .b         (iss_b_q),
    .op        (iss_op_q),
    .res       (alu_res),
    .carry     (alu_carry),
    .carry_upd (alu_carry_upd),
    .zero_upd  (alu_zero_upd)
  );

  always_comb begin
    // Writes to a nonexistent register are dropped, so they must not forward either.
    wb_en   = iss_vld_q && is_write(iss_op_q) && (32'(iss_rd_q) < NUM_REGS);
    wb_data = (iss_op_q == OP_LOAD) ? iss_in_q : alu_res;

    a_rf = (32'(rs1) < NUM_REGS) ? rf_q[rs1] : '0;
    b_rf = (32'(rs2) < NUM_REGS) ? rf_q[rs2] : '0;

    iss_vld_d = op_valid;
    iss_op_d  = op;
    iss_rd_d  = rd;
    iss_in_d  = in;
    iss_a_d   = (wb_en && iss_rd_q == rs1) ? wb_data : a_rf;
    iss_b_d   = (wb_en && iss_rd_q == rs2) ? wb_data : b_rf;

    rf_d = rf_q;
    if (wb_en) rf_d[iss_rd_q] = wb_data;

    cout_d    = cout_q;
    zero_d    = zero_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    if (iss_vld_q) begin
      if (alu_carry_upd) cout_d = alu_carry;
      if (alu_zero_upd)  zero_d = (alu_res == '0);
      if (iss_op_q == OP_MOVO) begin
        out_d     = iss_a_q;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q      <= '0;
      iss_vld_q <= 1'b0;
      iss_op_q  <= OP_NOP;
      iss_rd_q  <= '0;
      iss_in_q  <= '0;
      iss_a_q   <= '0;
      iss_b_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      iss_vld_q <= iss_vld_d;
      iss_op_q  <= iss_op_d;
      iss_rd_q  <= iss_rd_d;
      iss_in_q  <= iss_in_d;
      iss_a_q   <= iss_a_d;
      iss_b_q   <= iss_b_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_vld_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_data_path_pipe.sv
// Directed vectors for data_path_pipe; checks taken 1ns after each rising edge.
module tb_data_path_pipe;
  import dp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic [2:0] op;
  logic [1:0] rd, rs1, rs2;
  logic [7:0] in;
  logic [7:0] out;
  logic       out_valid, cout, zero;

  int n_vec  = 0;
  int n_miss = 0;

  data_path_pipe #(.BIT_WIDTH(8), .NUM_REGS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .cout      (cout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] o, input logic [1:0] d,
                      input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] din);
    op_valid = v; op = o; rd = d; rs1 = s1; rs2 = s2; in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    step(1'b0, OP_NOP, 2'd0, 2'd0, 2'd0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    bubble();
    rst_n = 1'b1;
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_ovld", 32'(out_valid), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);

    // 1: MOVO r0..r3 after reset, each one pulses out_valid with 0
    step(1'b1, OP_MOVO, 2'd0, 2'd0, 2'd0, 8'h00);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, OP_MOVO, 2'd0, 2'(i), 2'd0, 8'h00);
      chk("t1_out", 32'(out), 32'h00);
      chk("t1_ovld", 32'(out_valid), 32'h1);
    end
    bubble();
    chk("t1_out3", 32'(out), 32'h00);
    chk("t1_ovld3", 32'(out_valid), 32'h1);
    bubble();
    chk("t1_ovld_clr", 32'(out_valid), 32'h0);
    chk("t1_cout", 32'(cout), 32'h0);
    chk("t1_zero", 32'(zero), 32'h0);

    // 2: 0xF0 + 0x20 = 0x110
    step(1'b1, OP_LOAD, 2'd0, 2'd0, 2'd0, 8'hF0);
    step(1'b1, OP_LOAD, 2'd1, 2'd0, 2'd0, 8'h20);
    step(1'b1, OP_ADD,  2'd2, 2'd0, 2'd1, 8'h00);
    step(1'b1, OP_MOVO, 2'd0, 2'd2, 2'd0, 8'h00);
    chk("t2_cout", 32'(cout), 32'h1);
    chk("t2_zero", 32'(zero), 32'h0);
    bubble();
    chk("t2_out", 32'(out), 32'h10);
    chk("t2_ovld", 32'(out_valid), 32'h1);

    // 3: back-to-back dependent ops via forwarding: 5 -> 10 -> 20
    step(1'b1, OP_LOAD, 2'd1, 2'd0, 2'd0, 8'h05);
    step(1'b1, OP_ADD,  2'd1, 2'd1, 2'd1, 8'h00);
    step(1'b1, OP_ADD,  2'd1, 2'd1, 2'd1, 8'h00);
    step(1'b1, OP_MOVO, 2'd0, 2'd1, 2'd0, 8'h00);
    bubble();
    chk("t3_out", 32'(out), 32'h14);
    chk("t3_ovld", 32'(out_valid), 32'h1);
    chk("t3_cout", 32'(cout), 32'h0);

    // 4: SUB to zero, then SUB with borrow
    step(1'b1, OP_SUB,  2'd3, 2'd0, 2'd0, 8'h00);
    step(1'b1, OP_MOVO, 2'd0, 2'd3, 2'd0, 8'h00);
    chk("t4_zero", 32'(zero), 32'h1);
    chk("t4_cout", 32'(cout), 32'h1);
    bubble();
    chk("t4_out", 32'(out), 32'h00);
    step(1'b1, OP_LOAD, 2'd0, 2'd0, 2'd0, 8'h01);
    step(1'b1, OP_LOAD, 2'd1, 2'd0, 2'd0, 8'h02);
    step(1'b1, OP_SUB,  2'd2, 2'd0, 2'd1, 8'h00);
    step(1'b1, OP_MOVO, 2'd0, 2'd2, 2'd0, 8'h00);
    bubble();
    chk("t4_out_b", 32'(out), 32'hFF);
    chk("t4_cout_b", 32'(cout), 32'h0);
    chk("t4_zero_b", 32'(zero), 32'h0);

    // 5: logic ops leave cout alone; LOAD leaves both flags alone
    step(1'b1, OP_LOAD, 2'd0, 2'd0, 2'd0, 8'hFF);
    step(1'b1, OP_LOAD, 2'd1, 2'd0, 2'd0, 8'h01);
    step(1'b1, OP_ADD,  2'd2, 2'd0, 2'd1, 8'h00);
    bubble();
    chk("t5_add_cout", 32'(cout), 32'h1);
    chk("t5_add_zero", 32'(zero), 32'h1);
    step(1'b1, OP_OR, 2'd3, 2'd0, 2'd1, 8'h00);
    bubble();
    chk("t5_or_zero", 32'(zero), 32'h0);
    chk("t5_or_cout", 32'(cout), 32'h1);
    step(1'b1, OP_XOR, 2'd2, 2'd0, 2'd0, 8'h00);
    bubble();
    chk("t5_xor_zero", 32'(zero), 32'h1);
    chk("t5_xor_cout", 32'(cout), 32'h1);
    step(1'b1, OP_LOAD, 2'd3, 2'd0, 2'd0, 8'h55);
    step(1'b1, OP_MOVO, 2'd0, 2'd3, 2'd0, 8'h00);
    chk("t5_ld_zero", 32'(zero), 32'h1);
    chk("t5_ld_cout", 32'(cout), 32'h1);
    bubble();
    chk("t5_out", 32'(out), 32'h55);

    // 6: reset lands while ADD executes and MOVO issues
    step(1'b1, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00);
    rst_n = 1'b0;
    step(1'b1, OP_MOVO, 2'd0, 2'd2, 2'd0, 8'h00);
    rst_n = 1'b1;
    chk("t6_out", 32'(out), 32'h00);
    chk("t6_ovld", 32'(out_valid), 32'h0);
    chk("t6_cout", 32'(cout), 32'h0);
    chk("t6_zero", 32'(zero), 32'h0);
    bubble();
    chk("t6_drop", 32'(out_valid), 32'h0);
    chk("t6_out2", 32'(out), 32'h00);

    // bubble with LOAD fields must not write; RF must read back cleared
    step(1'b0, OP_LOAD, 2'd0, 2'd0, 2'd0, 8'hAA);
    step(1'b1, OP_MOVO, 2'd0, 2'd0, 2'd0, 8'h00);
    step(1'b1, OP_MOVO, 2'd0, 2'd2, 2'd0, 8'h00);
    chk("bub_r0", 32'(out), 32'h00);
    chk("bub_ovld", 32'(out_valid), 32'h1);
    step(1'b1, OP_MOVO, 2'd0, 2'd3, 2'd0, 8'h00);
    chk("t6_r2", 32'(out), 32'h00);
    bubble();
    chk("t6_r3", 32'(out), 32'h00);
    chk("t6_ovld3", 32'(out_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/data_path_pipe.md
Name: data_path_pipe

Overview:
Parametrised successor to the single-accumulator data path. It provides a NUM_REGS-entry register file with two read ports, a multi-op ALU and a 2-stage issue/execute pipeline with result forwarding. It also has carry and zero flags and a registered output port with a valid strobe. It sits between the control unit (which issues one op per cycle) and the external I/O bus.

Parameters:
BIT_WIDTH, 8, datapath width in bits (>=1)
NUM_REGS, 4, register-file depth (>=2); localparam ADDR_W = max(1, clog2(NUM_REGS))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
op_valid  input  1  op fields sampled this edge when 1; 0 = bubble
op  input  3  opcode (see package)
rd  input  ADDR_W  destination register
rs1  input  ADDR_W  source A
rs2  input  ADDR_W  source B
in  input  BIT_WIDTH  external data for LOAD
out  output  BIT_WIDTH  output register
out_valid  output  1  one-cycle pulse when out is updated
cout  output  1  carry flag
zero  output  1  zero flag

Behaviour:
- Reset: one clock with clk edge and rst_n=0 clears all RF entries, out, out_valid, cout, zero and both stage-valid bits. Ops in flight are discarded and do not write.
- Opcodes: LOAD=0 (rd<=in), ADD=1, SUB=2, AND=3, OR=4, XOR=5, MOVO=6 (out<=R[rs1]), NOP=7.
- Stage 1 (issue), at edge t with op_valid=1: capture op, rd, in, A=R[rs1], B=R[rs2].
- Forwarding: if stage 2 holds a valid writing op with rd == rs1/rs2, the operand takes the stage-2 ALU result instead of the RF value.
- Stage 2 (execute), cycle t+1: the ALU computes combinationally from stage-1 registers. At edge t+1, RF[rd], flags, out and out_valid update.
- Latency: result is architecturally visible 2 edges after issue. Back-to-back dependent ops need no stalls.
- Arithmetic: ADD computes {cout,res} = A+B. SUB computes res = A-B and sets cout = 1 when there is no borrow (A>=B). Both wrap modulo 2^BIT_WIDTH.
- Flags: ADD and SUB update cout and zero. AND, OR and XOR update zero only; cout holds. LOAD, MOVO and NOP leave both flags unchanged. zero = (res == 0).
- Writes: LOAD and the ALU ops write RF[rd]. MOVO and NOP do not write the RF.
- Output: MOVO sets out = A (forwarded value) and pulses out_valid for exactly one cycle. Otherwise out holds and out_valid = 0.
- Bubbles: op_valid=0 at an edge clears stage-1 valid, so stage 2 performs no update the next cycle.
- Out-of-range addresses (NUM_REGS not a power of 2): reads return 0, writes are ignored.
- Read and write of the same register in one cycle is covered by forwarding. The RF itself is write-after-read.

Decomposition:
- Package dp_pkg holds the opcode localparams (OP_LOAD..OP_NOP), OP_W=3, and an is_write(op) function.
- One natural sub-module: alu_ops (BIT_WIDTH param). It is purely combinational: inputs a, b, op; outputs res, carry, carry_upd, zero_upd.
- The register file and pipeline registers stay in the top.

Test Plan:
1. Reset: hold rst_n=0 for 2 clocks, then MOVO r0..r3 -> out=0x00 each time, out_valid pulses once per MOVO, cout=0, zero=0.
2. LOAD r0=0xF0, LOAD r1=0x20, ADD r2=r0+r1, MOVO r2 -> out=0x10, cout=1, zero=0.
3. Forwarding: LOAD r1=5, then ADD r1=r1+r1 twice back-to-back, then MOVO r1, all consecutive -> out=0x14 with no stall.
4. SUB r3=r0-r0 (r0=0xF0) -> r3=0, zero=1, cout=1. LOAD r0=1, LOAD r1=2, SUB r2=r0-r1 -> r2=0xFF, cout=0, zero=0.
5. Flag hold: set cout=1 via ADD 0xFF+0x01, then XOR r2=r0^r0 -> zero=1, cout stays 1. A following LOAD leaves both flags unchanged.
6. Reset mid-flight: issue ADD r2=r0+r1 and MOVO r2, and drive rst_n=0 at the edge where ADD is in stage 2 -> RF, out and flags all 0, no out_valid pulse, MOVO is dropped.
